gate_vector_checker: RTL and testbench

//  Self-checking exerciser for small combinational or pipelined logic gates.
//  It is the checking end of the gate-test interface.
//  - Drives every input vector 0 .. 2^N_IN-1 onto the DUT.
//  - Waits the DUT latency, samples the DUT output, compares it with the expected

---
 rtl/gate_vector_checker_if.sv | 16 +
 rtl/gate_vector_checker.sv | 63 ++++++
 tb/tb_gate_vector_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/gate_vector_checker_if.sv
// gate_vector_checker_if: gate-test bus between the vector checker and the harness driving the gate DUT.
interface gate_vector_checker_if #(parameter int N_IN = 2);
    logic            start;
    logic [N_IN-1:0] vec_out;
    logic            vec_valid;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail_vec;
    modport master (input start, dut_out,
                    output vec_out, vec_valid, busy, done, pass, err_count, first_fail_vec);
    modport slave  (output start, dut_out,
                    input vec_out, vec_valid, busy, done, pass, err_count, first_fail_vec);
endinterface

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps every input vector into a gate DUT and checks its output against an AND/OR/XOR reduction.
module gate_vector_checker #(
    parameter int N_IN = 2,
    parameter int OP   = 1,
    parameter int LAT  = 0
) (
    input logic clk,
    input logic rst,
    gate_vector_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
    localparam logic [3:0] LAT_W = 4'(LAT);
    state_t        state, nstate;
    logic [3:0]    wcnt;
    logic          exp_bit, hit, last, mis;
    logic [N_IN:0] err_next;
    if (OP > 2) begin : g_bad_op
        $error("gate_vector_checker: OP must be 0 (AND), 1 (OR) or 2 (XOR)");
    end
    assign exp_bit  = OP == 0 ? &bus.vec_out : OP == 1 ? |bus.vec_out : ^bus.vec_out;
    assign hit      = state == APPLY && wcnt == LAT_W;
    assign last     = hit && &bus.vec_out;
    assign mis      = hit && bus.dut_out != exp_bit;
    assign err_next = bus.err_count + {{N_IN{1'b0}}, mis};
    assign bus.busy      = state == APPLY;
    assign bus.vec_valid = state == APPLY;
    assign bus.done      = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end
    always_comb begin
        nstate = IDLE;
        nstate = state == IDLE  ? (bus.start ? APPLY : IDLE) :
                 state == APPLY ? (last ? DONE : APPLY) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.vec_out        <= '0;
            bus.err_count      <= '0;
            bus.pass           <= 1'b0;
            bus.first_fail_vec <= '0;
            wcnt               <= '0;
        end else if (state == IDLE && bus.start) begin
            bus.vec_out        <= '0;
            bus.err_count      <= '0;
            bus.pass           <= 1'b0;
            bus.first_fail_vec <= '0;
            wcnt               <= '0;
        end else if (state == APPLY) begin
            bus.err_count <= err_next;
            if (mis && bus.err_count == '0) bus.first_fail_vec <= bus.vec_out;
            wcnt <= hit ? 4'd0 : wcnt + 4'd1;
            // the final vector's own mismatch is folded in through err_next
            if (last) begin
                bus.vec_out <= '0;
                bus.pass    <= err_next == '0;
            end else if (hit) begin
                bus.vec_out <= bus.vec_out + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: directed sweeps of two checker instances (LAT=0 and LAT=2) against modelled OR gates.
module tb_gate_vector_checker;
    logic clk = 0, rst = 0, start_a = 0, start_b = 0;
    logic d1 = 0, db1 = 0, db2 = 0;
    int   mode = 0;
    int   nvec = 0, nmis = 0;
    typedef struct {logic [2:0] err; logic pass; logic [1:0] ffv;} res_t;
    res_t       rq[$];
    logic [1:0] vq[$];

    gate_vector_checker_if #(.N_IN(2)) ia ();
    gate_vector_checker_if #(.N_IN(2)) ib ();

    always #5 clk = ~clk;

    assign ia.start   = start_a;
    assign ib.start   = start_b;
    assign ia.dut_out = mode == 0 ? |ia.vec_out : mode == 1 ? 1'b0 : d1;
    assign ib.dut_out = db2;
    always @(posedge clk) begin
        d1  <= |ia.vec_out;
        db1 <= |ib.vec_out;
        db2 <= db1;
    end

    gate_vector_checker #(.N_IN(2), .OP(1), .LAT(0)) ua (.clk(clk), .rst(rst), .bus(ia));
    gate_vector_checker #(.N_IN(2), .OP(1), .LAT(2)) ub (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sig(input bit s, input int k);
        case (k)
            0: return s ? 32'(ib.busy) : 32'(ia.busy);
            1: return s ? 32'(ib.vec_valid) : 32'(ia.vec_valid);
            2: return s ? 32'(ib.done) : 32'(ia.done);
            3: return s ? 32'(ib.pass) : 32'(ia.pass);
            4: return s ? 32'(ib.err_count) : 32'(ia.err_count);
            5: return s ? 32'(ib.first_fail_vec) : 32'(ia.first_fail_vec);
            default: return s ? 32'(ib.vec_out) : 32'(ia.vec_out);
        endcase
    endfunction

    task automatic sweep(input bit s, input int exp_busy, input logic [2:0] err,
                         input logic pass, input logic [1:0] ffv);
        int   n = 0;
        bit   seen = 0;
        res_t r;
        rq.push_back('{err, pass, ffv});
        for (int v = 0; v < 4; v++)
            for (int k = 0; k <= (s ? 2 : 0); k++) vq.push_back(2'(v));
        @(negedge clk);
        if (s) start_b = 1; else start_a = 1;
        @(negedge clk);
        start_a = 0;
        start_b = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (sig(s, 0) == 1) begin
                n++;
                chk("vec_valid", sig(s, 1), 1);
                if (vq.size() != 0) chk("vec_out", sig(s, 6), 32'(vq.pop_front()));
            end else if (sig(s, 2) == 1) begin
                seen = 1;
                r = rq.pop_front();
                chk("err_count", sig(s, 4), 32'(r.err));
                chk("pass", sig(s, 3), 32'(r.pass));
                chk("first_fail_vec", sig(s, 5), 32'(r.ffv));
                chk("done_vec_out", sig(s, 6), 0);
                chk("busy_cycles", n, exp_busy);
            end else begin
                seen = 1;
                chk("busy_dropped_early", sig(s, 0), 1);
            end
            if (!seen) @(negedge clk);
        end
        if (!seen) chk("done_timeout", sig(s, 2), 1);
        chk("vectors_left", vq.size(), 0);
        vq.delete();
        rq.delete();
        @(negedge clk);
        chk("done_pulse_len", sig(s, 2), 0);
        chk("pass_held", sig(s, 3), 32'(pass));
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_vec_out", ia.vec_out, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_pass", ia.pass, 0);
        chk("rst_err", ia.err_count, 0);
        chk("rst_ffv", ia.first_fail_vec, 0);
        chk("rst_b_valid", ib.vec_valid, 0);
        @(negedge clk);
        rst = 0;
        // ideal OR gate, combinational
        mode = 0;
        sweep(0, 4, 3'd0, 1'b1, 2'b00);
        // stuck-at-0 output
        mode = 1;
        sweep(0, 4, 3'd3, 1'b0, 2'b01);
        // LAT=2 checker against a two-flop OR
        sweep(1, 12, 3'd0, 1'b1, 2'b00);
        // one-cycle-late DUT against the LAT=0 checker
        mode = 2;
        sweep(0, 4, 3'd1, 1'b0, 2'b01);
        // reset in the middle of a sweep
        mode = 0;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        for (int c = 0; c < 20 && ia.vec_out != 2'b10; c++) @(negedge clk);
        chk("pre_rst_vec", ia.vec_out, 2);
        #2 rst = 1;
        #1;
        chk("mid_rst_vec", ia.vec_out, 0);
        chk("mid_rst_busy", ia.busy, 0);
        chk("mid_rst_valid", ia.vec_valid, 0);
        chk("mid_rst_err", ia.err_count, 0);
        chk("mid_rst_ffv", ia.first_fail_vec, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_done", ia.done, 0);
        end
        rst = 0;
        sweep(0, 4, 3'd0, 1'b1, 2'b00);
        // start toggled during APPLY, then held high through DONE
        mode = 1;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        chk("t6_vec0", ia.vec_out, 0);
        @(negedge clk);
        start_a = 1;
        chk("t6_vec1", ia.vec_out, 1);
        @(negedge clk);
        start_a = 0;
        chk("t6_vec2", ia.vec_out, 2);
        @(negedge clk);
        start_a = 1;
        chk("t6_vec3", ia.vec_out, 3);
        @(negedge clk);
        chk("t6_done", ia.done, 1);
        chk("t6_err", ia.err_count, 3);
        @(negedge clk);
        chk("t6_idle_busy", ia.busy, 0);
        chk("t6_idle_done", ia.done, 0);
        chk("t6_idle_err_held", ia.err_count, 3);
        @(negedge clk);
        start_a = 0;
        chk("t6_restart_busy", ia.busy, 1);
        chk("t6_restart_vec", ia.vec_out, 0);
        chk("t6_restart_err", ia.err_count, 0);
        chk("t6_restart_ffv", ia.first_fail_vec, 0);
        chk("t6_restart_pass", ia.pass, 0);
        for (int c = 0; c < 20 && ia.done !== 1'b1; c++) @(negedge clk);
        chk("t6_second_done", ia.done, 1);
        chk("t6_second_err", ia.err_count, 3);
        chk("t6_second_ffv", ia.first_fail_vec, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
